// File: rtl/packet_sender_n_pkg.sv
// Debug-link package: UART frame constants, sender FSM states and the default
// sync value shared by the packet sender and its byte serialiser.
package packet_sender_n_pkg;
  localparam logic     UART_START   = 1'b0;
  localparam logic     UART_STOP    = 1'b1;
  localparam int       DATA_BITS    = 8;
  localparam int       FRAME_BITS   = DATA_BITS + 2;
  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;
endpackage

// File: rtl/packet_sender_n_if.sv
// Request/status bundle between the debug controller and the packet sender.
interface packet_sender_n_if #(
  parameter int NUM_BYTES = 6
);
  logic                   start;
  logic [NUM_BYTES*8-1:0] payload;
  logic                   txd;
  logic                   busy;
  logic                   done;
  logic                   byte_sent;

  modport master (output start, payload, input txd, busy, done, byte_sent);
  modport slave  (input start, payload, output txd, busy, done, byte_sent);
endinterface

// File: rtl/packet_sender_n_uart_tx_byte.sv
// 8N1 byte serialiser. A load on the cycle frame_done is high restarts the
// line with the next start bit, so back-to-back frames carry no idle gap.
module uart_tx_byte
  import packet_sender_n_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       frame_done,
  output logic       busy
);
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_MAX = 4'(FRAME_BITS - 1);

  logic [CNTW-1:0] cnt;
  logic [3:0]      bit_idx;
  logic [8:0]      shreg;

  assign frame_done = busy && (bit_idx == BIT_MAX) && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd     <= UART_STOP;
      shreg   <= '1;
      cnt     <= '0;
      bit_idx <= '0;
      busy    <= 1'b0;
    end else if (load) begin
      txd     <= UART_START;
      shreg   <= {UART_STOP, data};
      cnt     <= '0;
      bit_idx <= '0;
      busy    <= 1'b1;
    end else if (busy) begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        if (bit_idx == BIT_MAX) begin
          busy    <= 1'b0;
          bit_idx <= '0;
          txd     <= UART_STOP;
        end else begin
          // shreg holds data LSB-first followed by the stop bit
          bit_idx <= bit_idx + 1'b1;
          txd     <= shreg[0];
          shreg   <= {UART_STOP, shreg[8:1]};
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/packet_sender_n.sv
// N-byte UART packet sender: optional sync prefix, latched payload, optional
// XOR checksum, all sent as contiguous 8N1 frames with busy/done/byte strobes.
module packet_sender_n
  import packet_sender_n_pkg::*;
#(
  parameter int         NUM_BYTES    = 6,
  parameter int         CLKS_PER_BIT = 434,
  parameter bit         SYNC_EN      = 1'b1,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC,
  parameter bit         CHKSUM_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  packet_sender_n_if.slave bus
);
  localparam int F    = int'(SYNC_EN) + NUM_BYTES + int'(CHKSUM_EN);
  localparam int IDXW = $clog2(F + 1);
  localparam logic [IDXW-1:0] LAST = IDXW'(F - 1);

  state_t                     state;
  logic [IDXW-1:0]            idx, next_idx;
  logic [NUM_BYTES-1:0][7:0]  shadow, pl_bytes;
  logic [7:0]                 csum, pl_xor, cur_byte;
  logic                       busy_q, done_q, sent_q, fd_q;
  logic                       ser_load, ser_done, ser_busy, ser_txd;

  assign pl_bytes = bus.payload;

  always_comb begin
    pl_xor = '0;
    for (int i = 0; i < NUM_BYTES; i++) pl_xor ^= pl_bytes[i];
  end

  // In SEND the serialiser is reloaded for the following frame, so the mux
  // looks one index ahead to absorb the LOAD cycle.
  assign next_idx = (state == ST_SEND) ? idx + 1'b1 : idx;

  always_comb begin
    cur_byte = csum;
    if (SYNC_EN && next_idx == '0) begin
      cur_byte = SYNC_BYTE;
    end else begin
      for (int i = 0; i < NUM_BYTES; i++)
        if (int'(next_idx) == i + int'(SYNC_EN)) cur_byte = shadow[i];
    end
  end

  assign ser_load = (state == ST_LOAD && !ser_busy) ||
                    (state == ST_SEND && ser_done && idx != LAST);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .data       (cur_byte),
    .txd        (ser_txd),
    .frame_done (ser_done),
    .busy       (ser_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      shadow <= '0;
      csum   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sent_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // byte_sent trails frame end by one cycle so it lines up with done
      fd_q   <= ser_done;
      sent_q <= fd_q;
      case (state)
        ST_IDLE: if (bus.start) begin
          shadow <= pl_bytes;
          csum   <= pl_xor;
          idx    <= '0;
          busy_q <= 1'b1;
          state  <= ST_LOAD;
        end
        ST_LOAD: if (!ser_busy) state <= ST_SEND;
        ST_SEND: if (ser_done) begin
          if (idx == LAST) state <= ST_DONE;
          else             idx   <= idx + 1'b1;
        end
        ST_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.txd       = ser_txd;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.byte_sent = sent_q;
endmodule

// File: tb/tb_packet_sender_n.sv
// Bench for packet_sender_n: three configurations, line waveform compared
// cycle-by-cycle against frames built from the packet rules.
module tb_packet_sender_n;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam int NB[3] = '{6, 6, 1};
  localparam int SY[3] = '{1, 0, 0};
  localparam int CK[3] = '{1, 0, 1};
  localparam int CP[3] = '{4, 4, 2};

  logic line_q [0:2047];

  always #5 clk = ~clk;

  packet_sender_n_if #(.NUM_BYTES(6)) ia ();
  packet_sender_n_if #(.NUM_BYTES(6)) ib ();
  packet_sender_n_if #(.NUM_BYTES(1)) ic ();

  packet_sender_n #(.NUM_BYTES(6), .CLKS_PER_BIT(4), .SYNC_EN(1'b1),
                    .SYNC_BYTE(8'hA5), .CHKSUM_EN(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  packet_sender_n #(.NUM_BYTES(6), .CLKS_PER_BIT(4), .SYNC_EN(1'b0),
                    .SYNC_BYTE(8'hA5), .CHKSUM_EN(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  packet_sender_n #(.NUM_BYTES(1), .CLKS_PER_BIT(2), .SYNC_EN(1'b0),
                    .SYNC_BYTE(8'hA5), .CHKSUM_EN(1'b1))
    dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // {txd, busy, done, byte_sent}
  function automatic logic [3:0] obs(input int d);
    case (d)
      0:       return {ia.txd, ia.busy, ia.done, ia.byte_sent};
      1:       return {ib.txd, ib.busy, ib.done, ib.byte_sent};
      default: return {ic.txd, ic.busy, ic.done, ic.byte_sent};
    endcase
  endfunction

  task automatic drive_start(input int d, input logic v);
    case (d)
      0:       ia.start = v;
      1:       ib.start = v;
      default: ic.start = v;
    endcase
  endtask

  task automatic set_pl(input int d, input logic [47:0] v);
    case (d)
      0:       ia.payload = v;
      1:       ib.payload = v;
      default: ic.payload = v[7:0];
    endcase
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  // mode 0: single start pulse; 1: start held high; 2: random start pulses while busy
  task automatic pkt(input int d, input logic [47:0] pl, input int mode, input bit ovr_en);
    logic [7:0] exp_q[$];
    logic [7:0] x, got, eb;
    logic [3:0] s;
    logic       bs_at_done, busy_at_done, ebit;
    bit         ok, idle_ok;
    int         c, f_n, len, k, kk, done_k, bs_n;
    c = CP[d];
    x = '0;
    if (SY[d] != 0) exp_q.push_back(8'hA5);
    for (int i = 0; i < NB[d]; i++) begin
      exp_q.push_back(pl[i*8 +: 8]);
      x ^= pl[i*8 +: 8];
    end
    if (CK[d] != 0) exp_q.push_back(x);
    f_n = exp_q.size();
    len = f_n * 10 * c + 2;

    set_pl(d, pl);
    drive_start(d, 1'b1);
    @(posedge clk); #1;
    s = obs(d);
    chk("busy_rise", 64'(s[2]), 64'(1));
    if (mode != 1) drive_start(d, 1'b0);

    done_k = -1; bs_n = 0; bs_at_done = 1'b0; busy_at_done = 1'b1; k = 0;
    while (k < len + 5 && done_k < 0) begin
      k++;
      @(posedge clk); #1;
      s = obs(d);
      line_q[k] = s[3];
      if (s[0]) bs_n++;
      if (s[1]) begin
        done_k = k; bs_at_done = s[0]; busy_at_done = s[2];
      end
      if (ovr_en && k == 2) set_pl(d, '1);
      if (mode == 2) drive_start(d, (k < len - 3) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    chk("done_time", 64'(done_k), 64'(len));
    chk("byte_sent_cnt", 64'(bs_n), 64'(f_n));
    chk("byte_sent_with_done", 64'(bs_at_done), 64'(1));
    chk("busy_fall_at_done", 64'(busy_at_done), 64'(0));

    for (int f = 0; f < f_n; f++) begin
      ok = 1'b1; got = '0; eb = exp_q[f];
      for (int b = 0; b < 10; b++)
        for (int j = 0; j < c; j++) begin
          kk = 1 + f * 10 * c + b * c + j;
          ebit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
          if (line_q[kk] !== ebit) ok = 1'b0;
          if (b >= 1 && b <= 8 && j == c / 2) got[b-1] = line_q[kk];
        end
      chk("frame", {55'd0, ok, got}, {55'd0, 1'b1, eb});
    end
    idle_ok = 1'b1;
    for (int i = 10 * c * f_n + 1; i <= len; i++) if (line_q[i] !== 1'b1) idle_ok = 1'b0;
    chk("txd_idle_after", 64'(idle_ok), 64'(1));
  endtask

  initial begin
    logic [3:0] s;
    bit dseen, line_ok;
    ia.start = 1'b0; ib.start = 1'b0; ic.start = 1'b0;
    ia.payload = '0; ib.payload = '0; ic.payload = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("reset_state", 64'(obs(d)), 64'(4'b1000));
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // plain 6-byte packet, no sync/checksum
    pkt(1, 48'h060504030201, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    // sync + payload + checksum 0x70
    pkt(0, 48'h605040302010, 0, 1'b0);
    // payload overwritten mid-flight, then a packet carrying the new value
    pkt(0, 48'h605040302010, 0, 1'b1);
    pkt(0, 48'hFFFFFFFFFFFF, 0, 1'b0);
    // start held high, then re-pulses while busy; nothing queued afterwards
    pkt(0, rnd48(), 1, 1'b0);
    pkt(0, rnd48(), 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      s = obs(0);
      chk("no_queued_packet", 64'({s[3], s[2]}), 64'(2'b10));
    end

    // reset in data bit 3 of frame 2
    set_pl(0, rnd48());
    drive_start(0, 1'b1);
    @(posedge clk); #1;
    drive_start(0, 1'b0);
    dseen = 1'b0;
    for (int k = 1; k <= 98; k++) begin
      @(posedge clk); #1;
      s = obs(0);
      if (s[1]) dseen = 1'b1;
    end
    rst = 1'b1;
    #1;
    chk("rst_async", 64'(obs(0)), 64'(4'b1000));
    chk("rst_no_done_before", 64'(dseen), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    line_ok = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      s = obs(0);
      if (s !== 4'b1000) line_ok = 1'b0;
    end
    chk("rst_no_resume", 64'(line_ok), 64'(1));
    pkt(0, rnd48(), 0, 1'b0);

    // single byte with checksum at 2 clocks/bit
    pkt(2, 48'h5A, 0, 1'b0);

    for (int i = 0; i < 4; i++) pkt(int'($urandom_range(0, 2)), rnd48(), 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
